ffn_acc_requant: RTL and testbench
==================================

# ffn_acc_requant

Requantizer that sits directly upstream of the GELU lookup stage in the FFN datapath. It accepts signed Q12.20 matrix-multiply accumulator words and adds a per-column Q6.10 bias from an internal bias table. It then rounds, arithmetic-shifts and saturates the result to Q6.10 and streams it to the GELU stage over a valid/ready handshake. It also tracks column/row position and counts saturation events.

## Interface
- ACC_WIDTH, 32, accumulator width (signed, 2*FRAC_BITS fractional bits)
- DATA_WIDTH, 16, output/bias width (signed Q6.10)
- FRAC_BITS, 10, fractional bits of output and bias
- NUM_COLS, 64, columns per row; COL_W = $clog2(NUM_COLS) is a derived localparam

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- bias_we  in  1  bias table write strobe
- bias_addr  in  COL_W  bias write address
- bias_data  in  DATA_WIDTH  bias value, Q6.10
- col_clr  in  1  synchronous clear of column counter
- acc_in  in  ACC_WIDTH  accumulator word, Q12.20
- acc_valid  in  1  acc_in valid
- acc_ready  out  1  block can accept acc_in
- x_out  out  DATA_WIDTH  requantized result, Q6.10 (feeds GELU x_in)
- x_valid  out  1  x_out valid
- x_ready  in  1  downstream accepts x_out
- col_idx  out  COL_W  column of the beat on x_out
- row_last  out  1  beat on x_out is column NUM_COLS-1
- sat_flag  out  1  beat on x_out was saturated
- sat_count  out  16  saturating count of saturated beats delivered

## Operation
- Accept occurs when acc_valid && acc_ready. Deliver occurs when x_valid && x_ready.
- Pipeline enable: en = !x_valid || x_ready. acc_ready = en, which is combinational and reads 1 while x_valid = 0.
- Stage 1, on accept:
  - sum = sext(acc_in) + (sext(bias[col]) << FRAC_BITS), ACC_WIDTH+1 bits.
  - The column tag and last flag are captured with the sum.
- Stage 2:
  - Optional round (see Configuration), then arithmetic shift right by FRAC_BITS.
  - Saturate to [-32768, 32767]. sat_flag = 1 if clamped.
- Column counter:
  - Increments per accept and wraps NUM_COLS-1 -> 0.
  - col_clr forces it to 0. If col_clr coincides with an accept, that beat uses column 0 and the counter becomes 1.
- Bias table:
  - NUM_COLS x DATA_WIDTH registers, read combinationally.
  - A write in the same cycle as an accept of the same column gives that beat the old value. The new value applies from the next cycle.
  - Contents are not reset.
- sat_count increments on each delivered beat with sat_flag = 1 and holds at 0xFFFF.

## Timing
- Reset values: x_out 0, x_valid 0, col_idx 0, row_last 0, sat_flag 0, sat_count 0, column counter 0, both stage valids 0.
- Latency: accept in cycle N gives x_valid in cycle N+2 with no stall.
- Throughput: 1 beat/cycle while x_ready = 1.
- Stall: while x_valid && !x_ready, all stage registers and outputs hold and acc_ready = 0. Nothing is dropped or duplicated.
- Mid-operation reset: in-flight beats are discarded and outputs return to reset values immediately (asynchronous). The bias table is unaffected.

## Configuration
- FFN_REQ_ROUND_EN defined: add 1 << (FRAC_BITS-1) before the shift (round half toward +inf).
- FFN_REQ_ROUND_EN undefined: plain arithmetic shift (floor/truncate).
- Saturation, latency and the handshake are identical in both builds.

## Structure
- Shared package ffn_pkg:
  - Q6.10 constants: FRAC_BITS, DATA_WIDTH, Q_MAX = 16'sh7FFF, Q_MIN = 16'sh8000.
  - ROUND_HALF.
  - The ACC_WIDTH default.
- Sub-module q_requant_sat: combinational round, shift and saturate. Input is the (ACC_WIDTH+1)-bit sum; outputs are the DATA_WIDTH value and sat flag. Stage 2 instantiates it.

## Test plan
- Basic pass-through: bias all 0, acc_in = 0x00100000 (1.0) -> x_out = 0x0400, sat_flag = 0, 2-cycle latency.
- Bias add: bias[5] = 0x0200 (0.5), beat at column 5 with acc_in = 0x00100000 -> x_out = 0x0600, col_idx = 5.
- Rounding on a negative LSB: acc_in = 0xFFFFFFFF -> x_out = 0x0000 with FFN_REQ_ROUND_EN, x_out = 0xFFFF without it.
- Saturation:
  - acc_in = 0x7FFFFFFF -> x_out = 0x7FFF, sat_flag = 1.
  - acc_in = 0x80000000 -> x_out = 0x8000, sat_flag = 1.
  - sat_count = 2 after both are delivered.
- Back-pressure: stream 8 beats, hold x_ready = 0 for 3 cycles mid-stream. Required: acc_ready = 0 during the stall, x_out stable, all 8 values delivered in order.
- Wrap and clear:
  - 64 consecutive beats -> row_last = 1 only on beat 64 (col_idx 63), and the next beat has col_idx 0.
  - col_clr asserted with beat 10 -> that beat has col_idx 0 and the next beat has col_idx 1.

Source files
------------

// File: rtl/ffn_pkg.sv
// ---------------------------------------------------------------------------
// ffn_pkg
// Shared constants for the FFN requantization datapath.
//   FRAC_BITS / DATA_WIDTH : Q6.10 output and bias format
//   ACC_WIDTH              : default matrix-multiply accumulator width (Q12.20)
//   Q_MAX / Q_MIN          : Q6.10 saturation bounds
//   ROUND_HALF             : half-LSB of the Q6.10 result, in accumulator units
// ---------------------------------------------------------------------------
package ffn_pkg;
   localparam int FRAC_BITS  = 10;
   localparam int DATA_WIDTH = 16;
   localparam int ACC_WIDTH  = 32;

   localparam logic signed [DATA_WIDTH-1:0] Q_MAX = 16'sh7FFF;
   localparam logic signed [DATA_WIDTH-1:0] Q_MIN = 16'sh8000;

   localparam int ROUND_HALF = 1 << (FRAC_BITS - 1);
endpackage

// File: rtl/ffn_acc_requant_if.sv
// ---------------------------------------------------------------------------
// ffn_acc_requant_if
// Streaming bus of the requantizer: accumulator input handshake and the
// Q6.10 output handshake towards the GELU stage, plus per-beat sideband.
//   acc_in/acc_valid/acc_ready : accumulator words in (Q12.20)
//   x_out/x_valid/x_ready      : requantized words out (Q6.10)
//   col_idx/row_last/sat_flag  : sideband travelling with x_out
// Modports: master = producer of acc_in / consumer of x_out,
//           slave  = the requantizer itself.
// ---------------------------------------------------------------------------
interface ffn_acc_requant_if #(
   parameter int ACC_WIDTH  = ffn_pkg::ACC_WIDTH,
   parameter int DATA_WIDTH = ffn_pkg::DATA_WIDTH,
   parameter int COL_W      = 6
);
   logic [ACC_WIDTH-1:0]  acc_in;
   logic                  acc_valid;
   logic                  acc_ready;
   logic [DATA_WIDTH-1:0] x_out;
   logic                  x_valid;
   logic                  x_ready;
   logic [COL_W-1:0]      col_idx;
   logic                  row_last;
   logic                  sat_flag;

   modport master (
      output acc_in, acc_valid, x_ready,
      input  acc_ready, x_out, x_valid, col_idx, row_last, sat_flag
   );

   modport slave (
      input  acc_in, acc_valid, x_ready,
      output acc_ready, x_out, x_valid, col_idx, row_last, sat_flag
   );
endinterface

// File: rtl/q_requant_sat.sv
// ---------------------------------------------------------------------------
// q_requant_sat
// Combinational Q12.20(+1 bit) -> Q6.10 conversion: optional round,
// arithmetic shift right by FRAC_BITS, saturate to the Q6.10 range.
//   sum   in  ACC_WIDTH+1  signed biased accumulator sum
//   q_out out DATA_WIDTH   requantized value
//   sat   out 1            value was clamped
// Build option: FFN_REQ_ROUND_EN defined -> add half an output LSB before
// the shift (round half toward +inf); undefined -> floor.
// ---------------------------------------------------------------------------
module q_requant_sat #(
   parameter int ACC_WIDTH  = ffn_pkg::ACC_WIDTH,
   parameter int DATA_WIDTH = ffn_pkg::DATA_WIDTH,
   parameter int FRAC_BITS  = ffn_pkg::FRAC_BITS
) (
   input  logic signed [ACC_WIDTH:0]  sum,
   output logic [DATA_WIDTH-1:0]      q_out,
   output logic                       sat
);
   import ffn_pkg::*;

   // One guard bit above the sum so the rounding add can never wrap.
   localparam int RW = ACC_WIDTH + 2;

   logic signed [RW-1:0]       rounded;
   logic signed [RW-1:0]       shifted;
   logic [RW-DATA_WIDTH:0]     hi_bits;

`ifdef FFN_REQ_ROUND_EN
   assign rounded = RW'(sum) + RW'(ROUND_HALF);
`else
   assign rounded = RW'(sum);
`endif

   assign shifted = rounded >>> FRAC_BITS;

   // The result fits in DATA_WIDTH bits only if every bit from the output
   // sign bit upward is a copy of the same value.
   assign hi_bits = shifted[RW-1:DATA_WIDTH-1];
   assign sat     = !((&hi_bits) || !(|hi_bits));

   always_comb begin
      q_out = shifted[DATA_WIDTH-1:0];
      if (sat) begin
         q_out = hi_bits[RW-DATA_WIDTH] ? DATA_WIDTH'(Q_MIN) : DATA_WIDTH'(Q_MAX);
      end
   end
endmodule

// File: rtl/ffn_acc_requant.sv
// ---------------------------------------------------------------------------
// ffn_acc_requant
// Requantizer in front of the GELU lookup. Adds a per-column Q6.10 bias to
// each Q12.20 accumulator word, rounds/shifts/saturates to Q6.10 and streams
// the result out with column position and saturation sideband.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   bias_we/addr/data bias table write port (table is not reset)
//   col_clr           synchronous clear of the column counter
//   bus (slave)       acc_* input handshake, x_* output handshake + sideband
//   sat_count         saturating count of delivered saturated beats
// Two register stages: stage 1 holds the biased sum, stage 2 is the output.
// Both advance together on en = !x_valid || x_ready.
// Build option: FFN_REQ_ROUND_EN (see q_requant_sat).
// ---------------------------------------------------------------------------
module ffn_acc_requant #(
   parameter int  ACC_WIDTH  = ffn_pkg::ACC_WIDTH,
   parameter int  DATA_WIDTH = ffn_pkg::DATA_WIDTH,
   parameter int  FRAC_BITS  = ffn_pkg::FRAC_BITS,
   parameter int  NUM_COLS   = 64,
   localparam int COL_W      = $clog2(NUM_COLS)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  bias_we,
   input  logic [COL_W-1:0]      bias_addr,
   input  logic [DATA_WIDTH-1:0] bias_data,
   input  logic                  col_clr,
   ffn_acc_requant_if.slave      bus,
   output logic [15:0]           sat_count
);
   import ffn_pkg::*;

   localparam int               SUM_W    = ACC_WIDTH + 1;
   localparam logic [COL_W-1:0] LAST_COL = COL_W'(NUM_COLS - 1);

   // ---------------- handshake ----------------
   logic en;
   logic accept;

   logic                  x_valid_reg;
   logic [DATA_WIDTH-1:0] x_out_reg;
   logic [COL_W-1:0]      col_idx_reg;
   logic                  row_last_reg;
   logic                  sat_flag_reg;
   logic [15:0]           sat_count_reg;

   assign en            = !x_valid_reg || bus.x_ready;
   assign accept        = bus.acc_valid && en;
   assign bus.acc_ready = en;

   // ---------------- column counter ----------------
   logic [COL_W-1:0] col_cnt_reg;
   logic [COL_W-1:0] col_cnt_next;
   logic [COL_W-1:0] beat_col;

   // A clear coinciding with an accept makes that beat column 0.
   always_comb begin
      beat_col     = col_clr ? '0 : col_cnt_reg;
      col_cnt_next = col_cnt_reg;
      if (accept) begin
         col_cnt_next = (beat_col == LAST_COL) ? '0 : beat_col + 1'b1;
      end else if (col_clr) begin
         col_cnt_next = '0;
      end
   end

   // ---------------- bias table ----------------
   // Combinational read: a same-cycle write to the accepted column is not
   // yet visible, so that beat sees the old bias.
   logic [DATA_WIDTH-1:0] bias_mem [NUM_COLS];
   logic [DATA_WIDTH-1:0] bias_rd;

   always_ff @(posedge clk) begin
      if (bias_we) begin
         bias_mem[bias_addr] <= bias_data;
      end
   end

   assign bias_rd = bias_mem[beat_col];

   // ---------------- stage 1: bias add ----------------
   logic signed [DATA_WIDTH+FRAC_BITS-1:0] bias_shl;
   logic signed [SUM_W-1:0]                acc_ext;
   logic signed [SUM_W-1:0]                sum_next;

   assign bias_shl = {bias_rd, {FRAC_BITS{1'b0}}};
   assign acc_ext  = {bus.acc_in[ACC_WIDTH-1], bus.acc_in};
   assign sum_next = acc_ext + SUM_W'(bias_shl);

   logic                    s1_valid_reg;
   logic signed [SUM_W-1:0] s1_sum_reg;
   logic [COL_W-1:0]        s1_col_reg;
   logic                    s1_last_reg;

   // ---------------- stage 2: requantize ----------------
   logic [DATA_WIDTH-1:0] q_val;
   logic                  q_sat;

   q_requant_sat #(
      .ACC_WIDTH  (ACC_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .FRAC_BITS  (FRAC_BITS)
   ) u_q_requant_sat (
      .sum   (s1_sum_reg),
      .q_out (q_val),
      .sat   (q_sat)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_cnt_reg   <= '0;
         s1_valid_reg  <= 1'b0;
         s1_sum_reg    <= '0;
         s1_col_reg    <= '0;
         s1_last_reg   <= 1'b0;
         x_valid_reg   <= 1'b0;
         x_out_reg     <= '0;
         col_idx_reg   <= '0;
         row_last_reg  <= 1'b0;
         sat_flag_reg  <= 1'b0;
         sat_count_reg <= '0;
      end else begin
         col_cnt_reg <= col_cnt_next;

         if (en) begin
            s1_valid_reg <= accept;
            if (accept) begin
               s1_sum_reg  <= sum_next;
               s1_col_reg  <= beat_col;
               s1_last_reg <= (beat_col == LAST_COL);
            end

            x_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
               x_out_reg    <= q_val;
               col_idx_reg  <= s1_col_reg;
               row_last_reg <= s1_last_reg;
               sat_flag_reg <= q_sat;
            end
         end

         // Count on delivery, not on production, so a stalled beat is
         // counted exactly once.
         if (x_valid_reg && bus.x_ready && sat_flag_reg && (sat_count_reg != 16'hFFFF)) begin
            sat_count_reg <= sat_count_reg + 16'd1;
         end
      end
   end

   assign bus.x_valid  = x_valid_reg;
   assign bus.x_out    = x_out_reg;
   assign bus.col_idx  = col_idx_reg;
   assign bus.row_last = row_last_reg;
   assign bus.sat_flag = sat_flag_reg;
   assign sat_count    = sat_count_reg;
endmodule

// File: tb/tb_ffn_acc_requant.sv
// ---------------------------------------------------------------------------
// tb_ffn_acc_requant
// Self-checking bench for ffn_acc_requant. A behavioural model (integer
// arithmetic on the Q formats, a queue of expected beats) is updated on
// every falling edge from the observed handshakes; every delivered beat is
// compared against it. Directed phases add literal expectations.
// Honours FFN_REQ_ROUND_EN the same way as the design build.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ffn_acc_requant;
   localparam int NUM_COLS = 64;
   localparam int COL_W    = 6;

   logic              clk       = 1'b0;
   logic              rst_n     = 1'b0;
   logic              bias_we   = 1'b0;
   logic [COL_W-1:0]  bias_addr = '0;
   logic [15:0]       bias_data = '0;
   logic              col_clr   = 1'b0;
   logic [15:0]       sat_count;

   ffn_acc_requant_if #(.ACC_WIDTH(32), .DATA_WIDTH(16), .COL_W(COL_W)) bus ();

   ffn_acc_requant #(.NUM_COLS(NUM_COLS)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bias_we   (bias_we),
      .bias_addr (bias_addr),
      .bias_data (bias_data),
      .col_clr   (col_clr),
      .bus       (bus),
      .sat_count (sat_count)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input longint got, input longint exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct {
      logic [15:0] x;
      int          col;
      bit          last;
      bit          sat;
      int          cyc;
   } exp_t;

   typedef struct {
      logic [15:0] x;
      int          col;
      bit          last;
      bit          sat;
      int          lat;
   } dlv_t;

   logic [15:0] m_bias [NUM_COLS];
   int          m_col = 0;
   int          m_sat = 0;
   exp_t        exp_q[$];
   dlv_t        dq[$];

   function automatic exp_t model(input logic [31:0] acc, input logic [15:0] b,
                                  input int col, input int cyc);
      exp_t   e;
      longint v;
      longint q;
      v = longint'($signed(acc)) + longint'($signed(b)) * 1024;
`ifdef FFN_REQ_ROUND_EN
      v = v + 512;
`endif
      q = v >>> 10;
      e.sat = 1'b1;
      if (q > 32767)       e.x = 16'h7FFF;
      else if (q < -32768) e.x = 16'h8000;
      else begin
         e.x   = q[15:0];
         e.sat = 1'b0;
      end
      e.col  = col;
      e.last = (col == NUM_COLS - 1);
      e.cyc  = cyc;
      return e;
   endfunction

   // ---------------- monitor / compare ----------------
   int          cyc = 0;
   bit          prev_stall = 0;
   logic [15:0] prev_x = '0;

   always @(negedge clk) begin
      exp_t e;
      int   c;
      cyc++;
      if (!rst_n) begin
         prev_stall = 0;
      end else begin
         chk("acc_ready", bus.acc_ready, (!bus.x_valid || bus.x_ready));
         chk("sat_count", sat_count, m_sat);
         if (prev_stall) begin
            chk("stall_x_valid", bus.x_valid, 1);
            chk("stall_x_out", bus.x_out, prev_x);
         end
         prev_stall = bus.x_valid && !bus.x_ready;
         prev_x     = bus.x_out;

         if (bus.x_valid && bus.x_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL spurious_beat: got x_out 0x%0h, expected no beat", bus.x_out);
            end else begin
               e = exp_q.pop_front();
               chk("x_out", bus.x_out, e.x);
               chk("col_idx", bus.col_idx, e.col);
               chk("row_last", bus.row_last, e.last);
               chk("sat_flag", bus.sat_flag, e.sat);
               dq.push_back('{bus.x_out, int'(bus.col_idx), bus.row_last, bus.sat_flag, cyc - e.cyc});
               $display("beat x_out=0x%04h col=%0d last=%0b sat=%0b lat=%0d",
                        bus.x_out, bus.col_idx, bus.row_last, bus.sat_flag, cyc - e.cyc);
               if (e.sat && m_sat < 65535) m_sat++;
            end
         end

         if (bus.acc_valid && bus.acc_ready) begin
            c = col_clr ? 0 : m_col;
            exp_q.push_back(model(bus.acc_in, m_bias[c], c, cyc));
            m_col = (c == NUM_COLS - 1) ? 0 : c + 1;
         end else if (col_clr) begin
            m_col = 0;
         end

         if (bias_we) m_bias[bias_addr] = bias_data;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one word and return just after the edge that accepted it,
   // leaving valid low so back-to-back calls stream without gaps.
   task automatic send(input logic [31:0] v, input bit clr);
      int n;
      n = 0;
      bus.acc_valid = 1'b1;
      bus.acc_in    = v;
      col_clr       = clr;
      @(negedge clk);
      while (!bus.acc_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("accept_in_time", (n < 50), 1);
      tick();
      bus.acc_valid = 1'b0;
      col_clr       = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         tick();
         n++;
      end
      chk("drain_in_time", (n < 300), 1);
      tick();
      tick();
   endtask

   task automatic wr_bias(input int a, input logic [15:0] d);
      bias_we   = 1'b1;
      bias_addr = COL_W'(a);
      bias_data = d;
      tick();
      bias_we   = 1'b0;
   endtask

   function automatic logic [31:0] rand_acc();
      logic [31:0] r;
      case ($urandom_range(0, 4))
         0: r = $urandom;
         1: r = $urandom_range(0, 32'h03FF_FFFF) - 32'h0200_0000;
         2: r = $urandom_range(0, 1) ? 32'h7FFF_FFFF : 32'h8000_0000;
         3: r = ($urandom_range(0, 1) ? 32'h1FFF_FC00 : 32'hE000_0000) + $urandom_range(0, 2047) - 32'd1024;
         default: r = $urandom_range(0, 4095) - 32'd2048;
      endcase
      return r;
   endfunction

   // ---------------- main sequence ----------------
   initial begin
      int n_last;
      logic [15:0] exp_neg;
      bus.acc_valid = 1'b0;
      bus.acc_in    = '0;
      bus.x_ready   = 1'b1;

      #12;
      chk("rst_x_out", bus.x_out, 0);
      chk("rst_x_valid", bus.x_valid, 0);
      chk("rst_col_idx", bus.col_idx, 0);
      chk("rst_row_last", bus.row_last, 0);
      chk("rst_sat_flag", bus.sat_flag, 0);
      chk("rst_sat_count", sat_count, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      for (int i = 0; i < NUM_COLS; i++) wr_bias(i, 16'h0000);

      // pass-through, 2-cycle latency
      dq.delete();
      send(32'h0010_0000, 1'b0);
      drain();
      chk("t1_x_out", dq[0].x, 16'h0400);
      chk("t1_sat", dq[0].sat, 0);
      chk("t1_latency", dq[0].lat, 2);

      // bias add at column 5
      wr_bias(5, 16'h0200);
      dq.delete();
      for (int i = 0; i < 6; i++) send((i == 5) ? 32'h0010_0000 : 32'h0, (i == 0));
      drain();
      chk("t2_x_out", dq[5].x, 16'h0600);
      chk("t2_col_idx", dq[5].col, 5);
      wr_bias(5, 16'h0000);

      // negative LSB rounding
`ifdef FFN_REQ_ROUND_EN
      exp_neg = 16'h0000;
`else
      exp_neg = 16'hFFFF;
`endif
      dq.delete();
      send(32'hFFFF_FFFF, 1'b0);
      drain();
      chk("t3_neg_lsb", dq[0].x, exp_neg);

      // saturation both ways
      dq.delete();
      send(32'h7FFF_FFFF, 1'b0);
      send(32'h8000_0000, 1'b0);
      drain();
      chk("t4_pos_sat_x", dq[0].x, 16'h7FFF);
      chk("t4_pos_sat_flag", dq[0].sat, 1);
      chk("t4_neg_sat_x", dq[1].x, 16'h8000);
      chk("t4_neg_sat_flag", dq[1].sat, 1);
      chk("t4_sat_count", sat_count, 2);

      // back-pressure mid-stream
      dq.delete();
      fork
         begin
            for (int i = 0; i < 8; i++) send(32'(i + 1) << 20, 1'b0);
         end
         begin
            logic [15:0] hold;
            repeat (4) tick();
            bus.x_ready = 1'b0;
            for (int k = 0; k < 3; k++) begin
               @(negedge clk);
               if (k == 0) hold = bus.x_out;
               chk("t5_stall_acc_ready", bus.acc_ready, 0);
               chk("t5_stall_x_out", bus.x_out, hold);
            end
            tick();
            bus.x_ready = 1'b1;
         end
      join
      drain();
      chk("t5_count", dq.size(), 8);
      for (int i = 0; i < 8; i++) chk("t5_order", dq[i].x, (i + 1) << 10);

      // row wrap
      dq.delete();
      for (int i = 0; i < 65; i++) send($urandom_range(0, 32'h00FF_FFFF), (i == 0));
      drain();
      n_last = 0;
      for (int i = 0; i < 63; i++) n_last += int'(dq[i].last);
      chk("t6_early_last", n_last, 0);
      chk("t6_last_flag", dq[63].last, 1);
      chk("t6_last_col", dq[63].col, 63);
      chk("t6_wrap_col", dq[64].col, 0);

      // clear with beat 10
      dq.delete();
      for (int i = 0; i < 12; i++) send(32'(i) << 16, (i == 9));
      drain();
      chk("t7_clr_col", dq[9].col, 0);
      chk("t7_after_clr_col", dq[10].col, 1);

      // mid-operation reset; bias survives
      wr_bias(0, 16'h0100);
      for (int i = 0; i < 3; i++) send(32'h0050_0000, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      chk("t8_rst_x_valid", bus.x_valid, 0);
      chk("t8_rst_x_out", bus.x_out, 0);
      chk("t8_rst_col_idx", bus.col_idx, 0);
      chk("t8_rst_sat_flag", bus.sat_flag, 0);
      chk("t8_rst_sat_count", sat_count, 0);
      exp_q.delete();
      m_col = 0;
      m_sat = 0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      dq.delete();
      send(32'h0010_0000, 1'b0);
      drain();
      chk("t8_bias_kept", dq[0].x, 16'h0500);
      chk("t8_col_restart", dq[0].col, 0);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         tick();
         bus.acc_valid = ($urandom_range(0, 3) != 0);
         bus.acc_in    = rand_acc();
         bus.x_ready   = ($urandom_range(0, 3) != 0);
         col_clr       = ($urandom_range(0, 40) == 0);
         bias_we       = ($urandom_range(0, 7) == 0);
         bias_addr     = COL_W'($urandom);
         bias_data     = $urandom_range(0, 1) ? 16'($urandom) : 16'($urandom_range(0, 2047) - 1024);
      end
      tick();
      bus.acc_valid = 1'b0;
      bus.x_ready   = 1'b1;
      col_clr       = 1'b0;
      bias_we       = 1'b0;
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end
endmodule
